spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 157 +++++++++++++++
 tb/tb_spi_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: single-byte SPI master, CPOL=0, LSB first.
//
// A request on start (accepted only in IDLE) shifts masterDataToSend out on MOSI
// and shifts MISO into masterDataReceived. Each FSM phase (SETUP, HIGH, LOW, HOLD)
// lasts CLK_DIV clk cycles, so SCLK runs at clk / (2*CLK_DIV) and CS stays low for
// 17*CLK_DIV cycles per byte.
//
// Ports:
//   clk                 system clock, rising-edge active
//   reset               asynchronous active-low reset
//   start               transfer request, sampled on rising clk
//   masterDataToSend    byte to transmit
//   MISO                serial data from slave
//   SCLK                serial clock, idles low
//   CS                  active-low chip select, idles high
//   MOSI                serial data to slave
//   busy                high whenever a transfer is in progress
//   done                one-cycle pulse in the first IDLE cycle after a transfer
//   masterDataReceived  last complete byte received

module spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] masterDataToSend,
  input  logic       MISO,
  output logic       SCLK,
  output logic       CS,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [7:0] masterDataReceived
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] mdr_q, mdr_d;
  logic       sclk_q, sclk_d;
  logic       cs_q, cs_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic       div_end;

  assign div_end = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    mdr_d   = mdr_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    // Divider free-runs in every active phase; it wraps exactly when a phase ends.
    if (state_q != StIdle) begin
      div_d = div_end ? 8'd0 : div_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          tx_d    = masterDataToSend;
          cs_d    = 1'b0;
          mosi_d  = masterDataToSend[0];
          bit_d   = 3'd0;
          div_d   = 8'd0;
          state_d = StSetup;
        end
      end
      StSetup, StLow: begin
        if (div_end) begin
          sclk_d  = 1'b1;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (div_end) begin
          // Falling SCLK: slave changed MISO on the rising edge, so it is stable now.
          sclk_d = 1'b0;
          rx_d   = {MISO, rx_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StHold;
          end else begin
            // MOSI only moves while SCLK is low; tx_q[0] is the bit just sent.
            mosi_d  = tx_q[1];
            tx_d    = {1'b0, tx_q[7:1]};
            state_d = StLow;
          end
        end
      end
      StHold: begin
        if (div_end) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          mdr_d   = rx_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      mdr_q   <= 8'd0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      mdr_q   <= mdr_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign SCLK               = sclk_q;
  assign CS                 = cs_q;
  assign MOSI               = mosi_q;
  assign busy               = (state_q != StIdle);
  assign done               = done_q;
  assign masterDataReceived = mdr_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: table vectors, random transfers against a byte-level
// slave/reference model, and hand-written corner sequences (start during HIGH,
// reset mid-transfer, back-to-back with start held high at CLK_DIV=1).

module tb_spi_master;

  localparam int unsigned Div = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] tx_data;
  logic       miso = 1'b0;
  logic       sclk, cs, mosi, busy, done;
  logic [7:0] mdr;

  logic       start1;
  logic       miso1 = 1'b0;
  logic       sclk1, cs1, mosi1, busy1, done1;
  logic [7:0] mdr1;
  logic [7:0] tx1 = 8'h81;

  spi_master #(.CLK_DIV(Div)) u_dut (
    .clk                (clk),
    .reset              (rst_n),
    .start              (start),
    .masterDataToSend   (tx_data),
    .MISO               (miso),
    .SCLK               (sclk),
    .CS                 (cs),
    .MOSI               (mosi),
    .busy               (busy),
    .done               (done),
    .masterDataReceived (mdr)
  );

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk                (clk),
    .reset              (rst_n),
    .start              (start1),
    .masterDataToSend   (tx1),
    .MISO               (miso1),
    .SCLK               (sclk1),
    .CS                 (cs1),
    .MOSI               (mosi1),
    .busy               (busy1),
    .done               (done1),
    .masterDataReceived (mdr1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: samples MOSI on SCLK rising and presents its next bit on MISO
  // at the same edge (LSB first); CS rising rewinds it.
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  int         slave_idx = 0;
  always @(posedge sclk or posedge cs) begin
    if (cs) begin
      slave_idx <= 0;
    end else begin
      if (slave_idx < 8) begin
        slave_rx[slave_idx] <= mosi;
        miso                <= slave_tx[slave_idx];
      end
      slave_idx <= slave_idx + 1;
    end
  end

  // Free-running monitors for the CLK_DIV=2 instance.
  int   cs_low_cyc = 0, sclk_rises = 0, done_pulses = 0, mosi_bad = 0, mosi_ones = 0;
  logic sclk_prev = 1'b0, mosi_prev = 1'b0;
  always @(negedge clk) begin
    if (cs === 1'b0) cs_low_cyc <= cs_low_cyc + 1;
    if (sclk === 1'b1 && sclk_prev === 1'b0) sclk_rises <= sclk_rises + 1;
    if (done === 1'b1) done_pulses <= done_pulses + 1;
    if (sclk === 1'b1 && sclk_prev === 1'b1 && mosi !== mosi_prev) mosi_bad <= mosi_bad + 1;
    if (mosi === 1'b1) mosi_ones <= mosi_ones + 1;
    sclk_prev <= sclk;
    mosi_prev <= mosi;
  end

  // Full transfer with expected received byte and expected slave-side byte.
  task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] sb,
                      input logic [7:0] exp_rx, input logic [7:0] exp_slave);
    int c0, r0, d0, b0, o0, n;
    int exp_ones;
    @(negedge clk); #1;
    c0 = cs_low_cyc; r0 = sclk_rises; d0 = done_pulses; b0 = mosi_bad; o0 = mosi_ones;
    slave_tx = sb;
    tx_data  = tx;
    start    = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40 * Div + 20) begin
      @(negedge clk); #1;
      n++;
    end
    check($sformatf("%s done_seen", tag), 32'(done), 32'd1);
    @(negedge clk); #1;
    // Each bit sits on MOSI for one full SCLK period; bit 7 also spans HOLD.
    exp_ones = 2 * Div * $countones(tx) + (tx[7] ? Div : 0);
    check($sformatf("%s cs_low_cycles", tag), 32'(cs_low_cyc - c0), 32'(17 * Div));
    check($sformatf("%s sclk_rises", tag), 32'(sclk_rises - r0), 32'd8);
    check($sformatf("%s done_pulses", tag), 32'(done_pulses - d0), 32'd1);
    check($sformatf("%s mosi_change_sclk_high", tag), 32'(mosi_bad - b0), 32'd0);
    check($sformatf("%s mosi_high_cycles", tag), 32'(mosi_ones - o0), 32'(exp_ones));
    check($sformatf("%s master_rx", tag), 32'(mdr), 32'(exp_rx));
    check($sformatf("%s slave_rx", tag), 32'(slave_rx), 32'(exp_slave));
    check($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sb;
    logic [7:0] exp_rx;
    logic [7:0] exp_slave;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   n, r0, d0, busy_low, lo, hi, rises, d1;
    logic prev;
    logic [7:0] rtx, rsb;

    vecs[0] = '{tx: 8'hA5, sb: 8'h3C, exp_rx: 8'h3C, exp_slave: 8'hA5};
    vecs[1] = '{tx: 8'h00, sb: 8'hFF, exp_rx: 8'hFF, exp_slave: 8'h00};
    vecs[2] = '{tx: 8'h00, sb: 8'h00, exp_rx: 8'h00, exp_slave: 8'h00};
    vecs[3] = '{tx: 8'hFF, sb: 8'h81, exp_rx: 8'h81, exp_slave: 8'hFF};
    vecs[4] = '{tx: 8'h01, sb: 8'h80, exp_rx: 8'h80, exp_slave: 8'h01};

    rst_n   = 1'b0;
    start   = 1'b0;
    start1  = 1'b0;
    tx_data = 8'h00;
    #12;
    check("reset CS", 32'(cs), 32'd1);
    check("reset SCLK", 32'(sclk), 32'd0);
    check("reset MOSI", 32'(mosi), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rx", 32'(mdr), 32'd0);
    check("reset CS dut1", 32'(cs1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].sb, vecs[i].exp_rx, vecs[i].exp_slave);
    end

    for (int i = 0; i < 20; i++) begin
      rtx = 8'($urandom);
      rsb = 8'($urandom);
      xfer($sformatf("rand%0d", i), rtx, rsb, rsb, rtx);
    end

    // Second start during HIGH of bit 3 must be ignored.
    @(negedge clk); #1;
    r0 = sclk_rises; d0 = done_pulses;
    slave_tx = 8'hC3; tx_data = 8'h5A; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(sclk_rises - r0 >= 4 && sclk === 1'b1) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("mid_start reached_bit3_high", 32'(sclk), 32'd1);
    tx_data = 8'hFF; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    busy_low = 0; n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk); #1;
      n++;
    end
    check("mid_start busy_held", 32'(busy_low), 32'd0);
    repeat (4 * Div + 4) @(negedge clk);
    #1;
    check("mid_start done_pulses", 32'(done_pulses - d0), 32'd1);
    check("mid_start busy_idle", 32'(busy), 32'd0);
    check("mid_start rx", 32'(mdr), 32'hC3);
    check("mid_start slave_rx", 32'(slave_rx), 32'h5A);

    // Reset during LOW of bit 4 aborts without updating the received byte.
    xfer("pre_abort", 8'h11, 8'h96, 8'h96, 8'h11);
    @(negedge clk); #1;
    r0 = sclk_rises; d0 = done_pulses;
    slave_tx = 8'h44; tx_data = 8'h33; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(sclk_rises - r0 >= 5 && sclk === 1'b0) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("abort in_transfer", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort CS", 32'(cs), 32'd1);
    check("abort SCLK", 32'(sclk), 32'd0);
    check("abort MOSI", 32'(mosi), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort rx", 32'(mdr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * Div) @(negedge clk);
    #1;
    check("abort no_done", 32'(done_pulses - d0), 32'd0);
    check("abort idle_after", 32'(busy), 32'd0);
    check("abort rx_held", 32'(mdr), 32'd0);
    xfer("post_abort", 8'h6E, 8'hB9, 8'hB9, 8'h6E);

    // CLK_DIV=1 with start held high: 17-cycle CS-low windows, 1-cycle gaps.
    @(negedge clk); #1;
    start1 = 1'b1;
    n = 0;
    while (cs1 !== 1'b0 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    check("b2b first_cs_low", 32'(cs1), 32'd0);
    for (int t = 0; t < 3; t++) begin
      lo = 0; rises = 0; prev = sclk1;
      while (cs1 === 1'b0 && lo < 100) begin
        lo++;
        @(negedge clk); #1;
        if (sclk1 === 1'b1 && prev === 1'b0) rises++;
        prev = sclk1;
      end
      check($sformatf("b2b%0d cs_low_cycles", t), 32'(lo), 32'd17);
      check($sformatf("b2b%0d sclk_rises", t), 32'(rises), 32'd8);
      hi = 0; d1 = 0;
      while (cs1 === 1'b1 && hi < 100) begin
        if (done1 === 1'b1) d1++;
        hi++;
        @(negedge clk); #1;
      end
      check($sformatf("b2b%0d cs_high_gap", t), 32'(hi), 32'd1);
      check($sformatf("b2b%0d done", t), 32'(d1), 32'd1);
    end
    start1 = 1'b0;
    check("b2b rx", 32'(mdr1), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
